// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - time-multiplexed N-digit common-anode seven-segment driver
// Double-buffered digit load, hex/decimal decode, leading-zero blanking, registered pins.
module sseg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    hex_en,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              sseg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] hold_digits;
  logic [4*NUM_DIGITS-1:0] disp_digits;
  logic [NUM_DIGITS-1:0]   hold_dp;
  logic [NUM_DIGITS-1:0]   disp_dp;

  logic                    slot_end;
  logic                    frame_wrap;
  logic [3:0]              code;
  logic                    lz_acc;
  logic [NUM_DIGITS-1:0]   lz_zero;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;
  logic                    dp_next;

  assign slot_end   = (cnt == CNT_MAX);
  assign frame_wrap = slot_end && (idx == IDX_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      hold_digits <= '0;
      hold_dp     <= '0;
      disp_digits <= '0;
      disp_dp     <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
      if (load) begin
        hold_digits <= digits;
        hold_dp     <= dp_in;
      end
      // A load landing on the wrap cycle bypasses the hold buffer entirely.
      if (frame_wrap) begin
        if (load) begin
          disp_digits <= digits;
          disp_dp     <= dp_in;
        end else if (pending) begin
          disp_digits <= hold_digits;
          disp_dp     <= hold_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    code    = disp_digits[{idx, 2'b00} +: 4];
    lz_acc  = 1'b1;
    lz_zero = '0;
    // lz_zero[i]: digit i and all digits above it are zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_acc     = lz_acc & (disp_digits[4*i +: 4] == 4'd0);
      lz_zero[i] = lz_acc;
    end

    seg_next = 7'b1111111;
    case (code)
      4'h0: seg_next = 7'b0000001;
      4'h1: seg_next = 7'b1001111;
      4'h2: seg_next = 7'b0010010;
      4'h3: seg_next = 7'b0000110;
      4'h4: seg_next = 7'b1001100;
      4'h5: seg_next = 7'b0100100;
      4'h6: seg_next = 7'b0100000;
      4'h7: seg_next = 7'b0001111;
      4'h8: seg_next = 7'b0000000;
      4'h9: seg_next = 7'b0001100;
      4'hA: if (hex_en) seg_next = 7'b0001000;
      4'hB: if (hex_en) seg_next = 7'b1100000;
      4'hC: if (hex_en) seg_next = 7'b0110001;
      4'hD: if (hex_en) seg_next = 7'b1000010;
      4'hE: if (hex_en) seg_next = 7'b0110000;
      4'hF: if (hex_en) seg_next = 7'b0111000;
      default: seg_next = 7'b1111111;
    endcase
    if (blank_lz && (idx != '0) && lz_zero[idx]) begin
      seg_next = 7'b1111111;
    end

    // Anodes stay off for the first cycle of each slot to avoid ghosting.
    an_next = '1;
    if (cnt != '0) begin
      an_next[idx] = 1'b0;
    end
    dp_next = ~disp_dp[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an          <= '1;
      sseg        <= 7'b1111111;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= an_next;
      sseg        <= seg_next;
      dp          <= dp_next;
      frame_start <= (cnt == '0) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb/tb_sseg_scan_driver.sv - self-checking bench for sseg_scan_driver
// Frame-position reference model plus table vectors and multi-cycle corner sequences.
module tb_sseg_scan_driver;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int FP = ND * RD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        hex_en = 1'b1;
  logic        blank_lz = 1'b1;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        dp;
  logic        frame_start;

  sseg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .reset(reset), .digits(digits), .dp_in(dp_in), .load(load),
    .hex_en(hex_en), .blank_lz(blank_lz), .an(an), .sseg(sseg), .dp(dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_tab [16];

  // Reference model: position within frame, shown and held buffers.
  int          pos = 0;
  logic [15:0] m_disp = '0, m_hold = '0;
  logic [3:0]  m_dpd = '0, m_dph = '0;
  logic        m_pend = 1'b0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fs;

  typedef struct {
    logic [15:0]     d;
    logic [3:0]      dpi;
    logic            hx;
    logic            lz;
    logic [3:0][6:0] es;
    logic [3:0]      edp;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int i,
                                         input logic hx, input logic lz);
    int code;
    code = int'((v >> (4 * i)) & 16'hF);
    if (lz && i != 0 && (v >> (4 * i)) == 16'd0) return 7'b1111111;
    if (code >= 10 && !hx) return 7'b1111111;
    return seg_tab[code];
  endfunction

  task automatic cycle();
    int ix;
    @(posedge clk);
    if (reset) begin
      pos = 0; m_disp = '0; m_hold = '0; m_dpd = '0; m_dph = '0; m_pend = 1'b0;
      e_an = 4'hF; e_seg = 7'b1111111; e_dp = 1'b1; e_fs = 1'b0;
    end else begin
      ix    = pos / RD;
      e_an  = (pos % RD == 0) ? 4'hF : ~(4'b0001 << ix);
      e_seg = ref_seg(m_disp, ix, hex_en, blank_lz);
      e_dp  = ~m_dpd[ix];
      e_fs  = (pos == 0);
      if (pos == FP - 1) begin
        if (load) begin m_disp = digits; m_dpd = dp_in; end
        else if (m_pend) begin m_disp = m_hold; m_dpd = m_dph; end
        m_pend = 1'b0;
      end else if (load) begin
        m_pend = 1'b1;
      end
      if (load) begin m_hold = digits; m_dph = dp_in; end
      pos = (pos + 1) % FP;
    end
    #1;
    chk("model_an", 32'(an), 32'(e_an));
    chk("model_sseg", 32'(sseg), 32'(e_seg));
    chk("model_dp", 32'(dp), 32'(e_dp));
    chk("model_frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic wait_fs();
    for (int k = 0; k < FP + 4; k++) begin
      cycle();
      if (frame_start) break;
    end
    chk("fs_seen", 32'(frame_start), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]      an_seq [6];
    logic [3:0][6:0] cap_seg;
    logic [3:0]      cap_dp;
    int nfs, lastfs, bad, good;

    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010;
    seg_tab[3]  = 7'b0000110; seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0001100; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
    seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010; seg_tab[14] = 7'b0110000;
    seg_tab[15] = 7'b0111000;

    vecs[0] = '{16'h1234, 4'b0000, 1'b1, 1'b1,
                {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111};
    vecs[1] = '{16'h00A5, 4'b0000, 1'b1, 1'b1,
                {7'b1111111, 7'b1111111, 7'b0001000, 7'b0100100}, 4'b1111};
    vecs[2] = '{16'h00A5, 4'b0000, 1'b0, 1'b1,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100}, 4'b1111};
    vecs[3] = '{16'h0000, 4'b0100, 1'b1, 1'b1,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b1011};
    vecs[4] = '{16'h0000, 4'b0000, 1'b1, 1'b0,
                {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111};
    vecs[5] = '{16'hBCDE, 4'b0000, 1'b1, 1'b1,
                {7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000}, 4'b1111};
    vecs[6] = '{16'h0F07, 4'b1001, 1'b1, 1'b1,
                {7'b1111111, 7'b0111000, 7'b0000001, 7'b0001111}, 4'b0110};
    vecs[7] = '{16'h6890, 4'b0000, 1'b0, 1'b1,
                {7'b0100000, 7'b0000000, 7'b0001100, 7'b0000001}, 4'b1111};

    an_seq[0] = 4'hF; an_seq[1] = 4'hE; an_seq[2] = 4'hE;
    an_seq[3] = 4'hE; an_seq[4] = 4'hF; an_seq[5] = 4'hD;

    // Reset state
    cycle(); cycle();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_sseg", 32'(sseg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_fs", 32'(frame_start), 32'd0);

    // Reset release: anode sequence and frame period
    reset = 1'b0;
    nfs = 0; lastfs = -1;
    for (int k = 0; k < 2 * FP + 1; k++) begin
      cycle();
      if (k < 6) chk($sformatf("release_an%0d", k), 32'(an), 32'(an_seq[k]));
      if (k == 1) chk("release_digit0", 32'(sseg), 32'b0000001);
      if (frame_start) begin nfs++; lastfs = k; end
    end
    chk("release_fs_count", 32'(nfs), 32'd3);
    chk("release_fs_last", 32'(lastfs), 32'(2 * FP));

    // Table vectors: load mid-frame, observe one full frame after commit
    for (int v = 0; v < 8; v++) begin
      cycle(); cycle();
      digits = vecs[v].d; dp_in = vecs[v].dpi;
      hex_en = vecs[v].hx; blank_lz = vecs[v].lz;
      load = 1'b1; cycle(); load = 1'b0;
      wait_fs();
      cap_seg = {4{7'h55}}; cap_dp = 4'h5;
      for (int k = 1; k < FP; k++) begin
        cycle();
        for (int d = 0; d < ND; d++) begin
          if (an[d] == 1'b0) begin cap_seg[d] = sseg; cap_dp[d] = dp; end
        end
      end
      for (int d = 0; d < ND; d++)
        chk($sformatf("vec%0d_digit%0d", v, d), 32'(cap_seg[d]), 32'(vecs[v].es[d]));
      chk($sformatf("vec%0d_dp", v), 32'(cap_dp), 32'(vecs[v].edp));
    end

    // Two loads in one frame: only the second is ever shown
    hex_en = 1'b1; blank_lz = 1'b0;
    wait_fs();
    digits = 16'h1111; load = 1'b1; cycle(); load = 1'b0;
    cycle(); cycle();
    digits = 16'h2222; load = 1'b1; cycle(); load = 1'b0;
    bad = 0; good = 0;
    for (int k = 0; k < 2 * FP; k++) begin
      cycle();
      if (an != 4'hF && sseg == 7'b1001111) bad++;
      if (an != 4'hF && sseg == 7'b0010010) good++;
    end
    chk("two_loads_1111_seen", 32'(bad), 32'd0);
    chk("two_loads_2222_shown", 32'(good > 0), 32'd1);

    // Load on the frame-wrap cycle shows in the immediately following frame
    for (int k = 0; k < FP + 2 && pos != FP - 1; k++) cycle();
    digits = 16'h0008; load = 1'b1; cycle(); load = 1'b0;
    cycle();
    chk("wrap_load_fs", 32'(frame_start), 32'd1);
    chk("wrap_load_seg", 32'(sseg), 32'b0000000);
    cycle();
    chk("wrap_load_an", 32'(an), 32'hE);
    chk("wrap_load_seg2", 32'(sseg), 32'b0000000);

    // Reset mid-slot with a pending load discards it
    cycle();
    digits = 16'h8888; load = 1'b1; cycle(); load = 1'b0;
    cycle();
    reset = 1'b1; cycle();
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_sseg", 32'(sseg), 32'h7F);
    chk("midrst_dp", 32'(dp), 32'd1);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 2 * FP + 2; k++) begin
      cycle();
      if (an != 4'hF && sseg == 7'b0000000) bad++;
    end
    chk("midrst_pending_shown", 32'(bad), 32'd0);

    // Randomized traffic against the reference model
    for (int k = 0; k < 600; k++) begin
      load   = ($urandom % 6) == 0;
      digits = 16'($urandom);
      dp_in  = 4'($urandom);
      if (($urandom % 20) == 0) hex_en = ~hex_en;
      if (($urandom % 20) == 0) blank_lz = ~blank_lz;
      reset  = ($urandom % 97) == 0;
      cycle();
    end
    load = 1'b0; reset = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display. It accepts a packed vector of 4-bit digit codes and scans one digit at a time at a programmable refresh rate. Per-digit decode supports decimal-only or hex mode, with optional leading-zero blanking. A double-buffered load prevents tearing mid-frame. It sits between the arithmetic/counter datapath and the board's anode, segment and decimal-point pins.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 100000, clock cycles per digit slot (minimum 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- digits  in  4*NUM_DIGITS  digit codes; digit i is digits[4i+3:4i], digit 0 is least significant (rightmost).
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- load  in  1  single-cycle strobe; captures digits and dp_in.
- hex_en  in  1  1 = codes 10..15 display A..F; 0 = codes 10..15 blank. Sampled live.
- blank_lz  in  1  1 = blank leading zeros. Sampled live.
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low when driving.
- sseg  out  7  segments {a,b,c,d,e,f,g} = sseg[6:0], active-low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

## Operation
- Slot counter cnt counts 0..REFRESH_DIV-1 and wraps.
- Digit index idx advances on cnt wrap: 0,1,…,NUM_DIGITS-1,0.
- Buffering uses hold_reg and disp_reg, each holding digits and dp.
  - load sets hold_reg <= inputs and pending <= 1.
  - At frame wrap (cnt and idx both terminal), if pending: disp_reg <= hold_reg, pending <= 0.
  - load coincident with frame wrap: the inputs go straight into disp_reg, and pending ends 0.
  - Repeated loads within a frame: the last one wins.
- Decode is active-low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100.
  - With hex_en=1: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - With hex_en=0: codes 10..15 give 1111111 (blank).
- Leading-zero blanking (blank_lz=1): digit i is blanked (sseg=1111111) if it and every digit above it are 0. Digit 0 is never blanked. dp is unaffected by blanking.
- Anti-ghosting: while cnt==0, an = all ones. Otherwise an[idx]=0 and all other bits are 1.
- Width rules: cnt is width clog2(REFRESH_DIV); idx is width clog2(NUM_DIGITS), minimum 1. idx never takes values ≥ NUM_DIGITS.

## Timing
- All outputs are registered, with 1-cycle latency from (cnt, idx, disp_reg) to the pins.
- Reset values:
  - cnt=0, idx=0, pending=0, hold_reg=0, disp_reg=0.
  - an=all ones, sseg=1111111, dp=1, frame_start=0.
- First cycle after reset deassert: outputs reflect cnt=0, idx=0, so an=all ones.
- Second cycle after reset deassert: an=~1, sseg=0000001 (digit 0 shows "0").
- frame_start is asserted in the same output cycle that reflects idx=0, cnt=0.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles.
- A load becomes visible on the pins at most one frame period + 1 cycle later. The earliest case is load at frame wrap: visible 1 cycle later.
- Reset mid-frame: all state returns to reset values on the next edge, and pending loads are discarded.
- hex_en and blank_lz changes take effect on the pins 1 cycle after sampling.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4.
- Reset release with no load: an cycles 1111, 1110, 1110, 1110, 1111, 1101, …; sseg=0000001 on digit 0. Digits 1..3 show 1111111 when blank_lz=1 and 0000001 when blank_lz=0. frame_start pulses every 16 cycles.
- load digits=16'h1234 mid-frame: pins keep the old value until the next frame_start. Afterwards digit3→1001111, digit2→0010010, digit1→0000110, digit0→1001100.
- digits=16'h00A5:
  - hex_en=1, blank_lz=1: digit1=0001000, digit0=0100100, digits 3..2 blank.
  - hex_en=0: digit1 blank, and digits 3..2 are still blank (code 0, leading).
- digits=16'h0000, blank_lz=1: only digit 0 shows 0000001. With dp_in=4'b0100, dp=0 only during the digit-2 slot, even though that digit is blanked.
- Two loads in one frame (16'h1111 then 16'h2222): only 2222 is ever displayed. A load on the frame-wrap cycle is displayed starting at the immediately following frame.
- Reset asserted mid-slot with load pending: the next cycle gives an=1111, sseg=1111111, dp=1. The pending value is never displayed.
